// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris playfield: default geometry, colour codes
// and the state encoding of the line-clear engine.
package tetris_pkg;

  localparam int ROWS_DEF = 20;
  localparam int COLS_DEF = 10;
  localparam int CW_DEF   = 3;

  localparam logic [CW_DEF-1:0] C_EMPTY = 3'd0;
  localparam logic [CW_DEF-1:0] C_I     = 3'd1;
  localparam logic [CW_DEF-1:0] C_O     = 3'd2;
  localparam logic [CW_DEF-1:0] C_T     = 3'd3;
  localparam logic [CW_DEF-1:0] C_J     = 3'd4;
  localparam logic [CW_DEF-1:0] C_L     = 3'd5;
  localparam logic [CW_DEF-1:0] C_S     = 3'd6;
  localparam logic [CW_DEF-1:0] C_Z     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } clr_state_e;

endpackage

// File: rtl/row_full_detect.sv
// Combinational row classifier: reports whether every cell of a row is
// occupied, or (ANY_MODE) whether at least one cell is occupied.
module row_full_detect
  import tetris_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int CW       = CW_DEF,
  parameter bit ANY_MODE = 1'b0
) (
  input  logic [COLS*CW-1:0] row_i,
  output logic               hit_o
);

  logic all_nz;
  logic any_nz;

  always_comb begin
    all_nz = 1'b1;
    any_nz = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      all_nz = all_nz & (row_i[c*CW +: CW] != '0);
      any_nz = any_nz | (row_i[c*CW +: CW] != '0);
    end
  end

  assign hit_o = ANY_MODE ? any_nz : all_nz;

endmodule

// File: rtl/playfield_mem.sv
// Tetris playfield store with a registered read port, a lock-down write port
// and a line-clear engine that removes full rows and drops the rows above.
module playfield_mem
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int CW   = CW_DEF,
  parameter int RAW  = $clog2(ROWS),
  parameter int CAW  = $clog2(COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RAW-1:0]            rd_row,
  input  logic [CAW-1:0]            rd_col,
  output logic [CW-1:0]             rd_val,
  input  logic                      wr_en,
  input  logic [RAW-1:0]            wr_row,
  input  logic [CAW-1:0]            wr_col,
  input  logic [CW-1:0]             wr_val,
  input  logic                      clr_start,
  output logic                      busy,
  output logic                      clr_done,
  output logic [$clog2(ROWS+1)-1:0] lines_cleared,
  output logic                      top_occupied
);

  localparam int LCW = $clog2(ROWS+1);
  localparam logic [RAW:0]   ROWS_W   = (RAW+1)'(ROWS);
  localparam logic [CAW:0]   COLS_W   = (CAW+1)'(COLS);
  localparam logic [RAW-1:0] LAST_ROW = RAW'(ROWS-1);

  // Whole-row shifts need every row visible at once, so storage is flops.
  logic [ROWS-1:0][COLS-1:0][CW-1:0] cells_q;

  clr_state_e     state_q, state_d;
  logic [RAW-1:0] r_q, r_d;
  logic [RAW-1:0] k_q, k_d;
  logic [LCW-1:0] cnt_q, cnt_d;
  logic [LCW-1:0] lines_q, lines_d;
  logic [CW-1:0]  rd_val_q;
  logic           top_q;

  logic [COLS*CW-1:0] scan_row;
  logic [COLS*CW-1:0] top_row;
  logic               scan_full;
  logic               top_any;
  logic               rd_in_range;
  logic               wr_ok;
  logic               do_shift;

  assign scan_row = cells_q[r_q];
  assign top_row  = cells_q[0];

  row_full_detect #(.COLS(COLS), .CW(CW), .ANY_MODE(1'b0)) u_scan_full (
    .row_i (scan_row),
    .hit_o (scan_full)
  );

  row_full_detect #(.COLS(COLS), .CW(CW), .ANY_MODE(1'b1)) u_top_any (
    .row_i (top_row),
    .hit_o (top_any)
  );

  assign rd_in_range = ({1'b0, rd_row} < ROWS_W) && ({1'b0, rd_col} < COLS_W);
  assign wr_ok       = (state_q == ST_IDLE) && wr_en &&
                       ({1'b0, wr_row} < ROWS_W) && ({1'b0, wr_col} < COLS_W);

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    lines_d  = lines_q;
    do_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_SCAN;
          r_d     = LAST_ROW;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (scan_full) begin
          state_d = ST_SHIFT;
          k_d     = r_q;
          cnt_d   = cnt_q + LCW'(1);
        end else if (r_q != '0) begin
          r_d = r_q - RAW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        do_shift = 1'b1;
        // r stays put so the row that drops into it gets rechecked.
        if (k_q != '0) k_d = k_q - RAW'(1);
        else           state_d = ST_SCAN;
      end
      ST_DONE: begin
        lines_d = cnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
    end
  end

  // Writes only happen in IDLE and shifts only in SHIFT, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cells_q <= '0;
    end else if (wr_ok) begin
      cells_q[wr_row][wr_col] <= wr_val;
    end else if (do_shift) begin
      if (k_q != '0) cells_q[k_q] <= cells_q[k_q - RAW'(1)];
      else           cells_q[0]   <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_val_q <= '0;
      top_q    <= 1'b0;
    end else begin
      rd_val_q <= rd_in_range ? cells_q[rd_row][rd_col] : '0;
      top_q    <= top_any;
    end
  end

  assign rd_val        = rd_val_q;
  assign top_occupied  = top_q;
  assign lines_cleared = lines_q;
  assign busy          = (state_q != ST_IDLE);
  assign clr_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_playfield_mem.sv
// Randomised self-checking bench for playfield_mem against a row-level
// reference model of the line-clear result and pass latency.
module tb_playfield_mem;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 3;
  localparam int RAW  = $clog2(ROWS);
  localparam int CAW  = $clog2(COLS);
  localparam int LCW  = $clog2(ROWS+1);

  logic           clk = 1'b0;
  logic           reset;
  logic [RAW-1:0] rd_row;
  logic [CAW-1:0] rd_col;
  logic [CW-1:0]  rd_val;
  logic           wr_en;
  logic [RAW-1:0] wr_row;
  logic [CAW-1:0] wr_col;
  logic [CW-1:0]  wr_val;
  logic           clr_start;
  logic           busy;
  logic           clr_done;
  logic [LCW-1:0] lines_cleared;
  logic           top_occupied;

  int checks = 0;
  int errors = 0;
  int model [ROWS][COLS];

  always #5 clk = ~clk;

  playfield_mem #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_val        (rd_val),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_val        (wr_val),
    .clr_start     (clr_start),
    .busy          (busy),
    .clr_done      (clr_done),
    .lines_cleared (lines_cleared),
    .top_occupied  (top_occupied)
  );

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    clear_model();
  endtask

  task automatic wr(input int r, input int c, input int v);
    wr_row = RAW'(r);
    wr_col = CAW'(c);
    wr_val = CW'(v);
    wr_en  = 1'b1;
    tick();
    wr_en  = 1'b0;
    if (r < ROWS && c < COLS) model[r][c] = v;
  endtask

  task automatic rd(input int r, input int c, output int v);
    rd_row = RAW'(r);
    rd_col = CAW'(c);
    tick();
    v = int'(rd_val);
  endtask

  task automatic check_board(input string tag);
    int v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rd(r, c, v);
        checks++;
        if (v !== model[r][c]) begin
          errors++;
          $display("FAIL %s cell(%0d,%0d): got %0d expected %0d", tag, r, c, v, model[r][c]);
        end
      end
  endtask

  // Full rows vanish, survivors keep their order and settle at the bottom.
  // A full row is detected at its original index plus the number of full rows
  // below it; each costs that index + 1 shift cycles + 1 rescan cycle.
  task automatic model_clear(output int lines, output int lat);
    bit full [ROWS];
    int dst;
    lines = 0;
    lat   = ROWS + 1;
    for (int r = ROWS-1; r >= 0; r--) begin
      full[r] = 1'b1;
      for (int c = 0; c < COLS; c++) if (model[r][c] == 0) full[r] = 1'b0;
      if (full[r]) begin
        lat += (r + lines) + 2;
        lines++;
      end
    end
    dst = ROWS - 1;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (!full[r]) begin
        for (int c = 0; c < COLS; c++) model[dst][c] = model[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < COLS; c++) model[r][c] = 0;
  endtask

  task automatic run_pass(input string tag, input bit with_wr, input int wr_r,
                          input int wr_c, input int wr_v);
    int lines, lat, n;
    if (with_wr) begin
      wr_row = RAW'(wr_r);
      wr_col = CAW'(wr_c);
      wr_val = CW'(wr_v);
      wr_en  = 1'b1;
      model[wr_r][wr_c] = wr_v;
    end
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr_en     = 1'b0;
    model_clear(lines, lat);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", tag, busy);
    end
    n = 1;
    while (clr_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s pass_latency: got %0d cycles expected %0d", tag, n, lat);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || int'(lines_cleared) !== lines) begin
      errors++;
      $display("FAIL %s after_done: busy=%b done=%b lines=%0d expected busy=0 done=0 lines=%0d",
               tag, busy, clr_done, lines_cleared, lines);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (rd_val !== '0 || busy !== 1'b0 || clr_done !== 1'b0 ||
        lines_cleared !== '0 || top_occupied !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd_val=%0d busy=%b done=%b lines=%0d top=%b expected all 0",
               rd_val, busy, clr_done, lines_cleared, top_occupied);
    end
    check_board("reset_board");
  endtask

  task automatic test_rw;
    int v;
    do_reset();
    rd_row = RAW'(3);
    rd_col = CAW'(4);
    wr(3, 4, 5);
    checks++;
    if (rd_val !== CW'(0)) begin
      errors++;
      $display("FAIL rw_read_during_write: got %0d expected 0", rd_val);
    end
    tick();
    checks++;
    if (rd_val !== CW'(5)) begin
      errors++;
      $display("FAIL rw_read_after_write: got %0d expected 5", rd_val);
    end
    wr(3, 12, 6);
    wr(25, 4, 7);
    rd(25, 4, v);
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL rw_read_row25: got %0d expected 0", v);
    end
    rd(3, 12, v);
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL rw_read_col12: got %0d expected 0", v);
    end
    check_board("rw_board");
  endtask

  task automatic test_clear_single;
    int v;
    do_reset();
    for (int c = 0; c < COLS; c++) wr(19, c, 2);
    wr(18, 0, 7);
    run_pass("clear_single", 1'b0, 0, 0, 0);
    rd(19, 0, v);
    checks++;
    if (v !== 7) begin
      errors++;
      $display("FAIL clear_single_drop: got %0d expected 7", v);
    end
    check_board("clear_single_board");
  endtask

  task automatic test_clear_double;
    do_reset();
    for (int c = 0; c < COLS; c++) begin
      wr(18, c, $urandom_range(1, 7));
      wr(19, c, $urandom_range(1, 7));
    end
    wr(17, 5, 3);
    run_pass("clear_double", 1'b0, 0, 0, 0);
    check_board("clear_double_board");
  endtask

  task automatic test_busy_ignore;
    int lines, lat, n, ndone, first;
    do_reset();
    for (int c = 0; c < COLS; c++) wr(19, c, 1 + (c % 7));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    model_clear(lines, lat);
    tick();
    wr_row = RAW'(0);
    wr_col = CAW'(0);
    wr_val = CW'(1);
    wr_en  = 1'b1;
    clr_start = 1'b1;
    tick();
    wr_en = 1'b0;
    clr_start = 1'b0;
    n = 3;
    ndone = 0;
    first = -1;
    for (int i = 0; i < 150; i++) begin
      if (clr_done === 1'b1) begin
        ndone++;
        if (first < 0) first = n;
      end
      tick();
      n++;
    end
    checks++;
    if (ndone !== 1 || first !== lat) begin
      errors++;
      $display("FAIL busy_ignore_done: pulses=%0d at cycle %0d expected 1 at cycle %0d",
               ndone, first, lat);
    end
    checks++;
    if (int'(lines_cleared) !== lines) begin
      errors++;
      $display("FAIL busy_ignore_lines: got %0d expected %0d", lines_cleared, lines);
    end
    check_board("busy_ignore_board");
  endtask

  task automatic test_top_occupied;
    do_reset();
    wr(0, 9, 4);
    checks++;
    if (top_occupied !== 1'b0) begin
      errors++;
      $display("FAIL top_lag: got %b expected 0", top_occupied);
    end
    tick();
    checks++;
    if (top_occupied !== 1'b1) begin
      errors++;
      $display("FAIL top_set: got %b expected 1", top_occupied);
    end
    for (int c = 0; c < COLS-1; c++) wr(0, c, 1 + (c % 7));
    run_pass("top_clear", 1'b0, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (top_occupied !== 1'b0) begin
      errors++;
      $display("FAIL top_cleared: got %b expected 0", top_occupied);
    end
    check_board("top_board");
  endtask

  task automatic test_reset_mid_pass;
    int seen;
    do_reset();
    for (int c = 0; c < COLS; c++) wr(19, c, 3);
    run_pass("pre_reset_pass", 1'b0, 0, 0, 0);
    for (int c = 0; c < COLS; c++) wr(19, c, 6);
    rd_row = RAW'(19);
    rd_col = CAW'(0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || lines_cleared !== '0 || rd_val !== '0) begin
      errors++;
      $display("FAIL reset_mid_pass: busy=%b done=%b lines=%0d rd_val=%0d expected all 0",
               busy, clr_done, lines_cleared, rd_val);
    end
    tick();
    reset = 1'b1;
    clear_model();
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (clr_done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_pass_quiet: got %0d busy/done cycles expected 0", seen);
    end
    check_board("reset_mid_pass_board");
  endtask

  task automatic test_random;
    int mode, zc;
    do_reset();
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        mode = $urandom_range(0, 2);
        zc = $urandom_range(0, COLS-1);
        for (int c = 0; c < COLS; c++) begin
          if (mode == 0)                   wr(r, c, $urandom_range(1, 7));
          else if (mode == 1 && c != zc)   wr(r, c, $urandom_range(0, 7));
          else                             wr(r, c, 0);
        end
      end
      run_pass("random", 1'b1, $urandom_range(0, ROWS-1), $urandom_range(0, COLS-1),
               $urandom_range(1, 7));
      check_board("random_board");
    end
  endtask

  initial begin
    reset     = 1'b0;
    rd_row    = '0;
    rd_col    = '0;
    wr_en     = 1'b0;
    wr_row    = '0;
    wr_col    = '0;
    wr_val    = '0;
    clr_start = 1'b0;
    test_reset();
    test_rw();
    test_clear_single();
    test_clear_double();
    test_busy_ignore();
    test_top_occupied();
    test_reset_mid_pass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/playfield_mem.md
Name: playfield_mem

Overview:
Parametrised Tetris playfield store. It holds ROWS x COLS cells of CW-bit colour codes, where 0 means empty. It provides a registered read port for the video renderer and a single write port for piece lock-down. It also contains a line-clear engine that finds full rows, removes them, and shifts the rows above down. It sits between the game-logic FSM and the VGA tile renderer.

Parameters:
ROWS, 20, playfield height in rows; row 0 is the top.
COLS, 10, playfield width in columns.
CW, 3, colour code width; code 0 means empty.
RAW, $clog2(ROWS), row address width (derived).
CAW, $clog2(COLS), column address width (derived).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
rd_row  in  RAW  read row address
rd_col  in  CAW  read column address
rd_val  out  CW  cell contents, registered, 1-cycle latency
wr_en  in  1  write strobe
wr_row  in  RAW  write row address
wr_col  in  CAW  write column address
wr_val  in  CW  value to write
clr_start  in  1  single-cycle pulse that starts a line-clear pass
busy  out  1  high while the line-clear engine is running
clr_done  out  1  single-cycle pulse when a pass completes
lines_cleared  out  $clog2(ROWS+1)  number of rows removed by the last pass
top_occupied  out  1  registered; high if any cell in row 0 is non-zero (game-over hint)

Behaviour:
- Reset (reset=0, asynchronous):
  - All cells are set to 0.
  - rd_val, busy, clr_done, lines_cleared and top_occupied are 0.
  - FSM goes to IDLE.
  - Reset asserted mid-pass aborts the pass; no done pulse is emitted.
- Read:
  - rd_val <= cell[rd_row][rd_col] on every clk edge, in every state.
  - During a pass, rd_val shows intermediate contents.
  - Out-of-range address (rd_row>=ROWS or rd_col>=COLS): rd_val <= 0.
- Write:
  - Accepted only in IDLE when wr_en=1 and the address is in range; it commits at that edge.
  - Writes while busy=1, or to out-of-range addresses, are silently dropped.
  - A read of the same cell issued on the write cycle returns the old value; the new value is visible from the next cycle.
- FSM states: IDLE, SCAN, SHIFT, DONE. Internal registers: row pointer r, shift pointer k, counter cnt.
  - IDLE:
    - clr_start=1 -> SCAN, with r=ROWS-1, cnt=0, busy=1 from the next cycle.
    - A write and clr_start in the same cycle: the write commits first, and the pass sees it.
  - SCAN (1 cycle per row):
    - Row r is full (every cell non-zero) -> SHIFT, with k=r and cnt+1.
    - Row r not full and r>0 -> r-1, stay in SCAN.
    - Row r not full and r==0 -> DONE.
  - SHIFT (1 row per cycle):
    - k>0: row[k] <= row[k-1], then k-1.
    - k==0: row[0] <= all zeros, then return to SCAN at the same r, so the row that dropped in is rechecked.
  - DONE (1 cycle):
    - clr_done=1 and lines_cleared <= cnt; busy drops next cycle; -> IDLE.
    - lines_cleared holds its value until the next DONE.
- clr_start while busy is ignored.
- Pass latency with no full rows: ROWS SCAN cycles + 1 DONE cycle.
  - Each cleared row at index r adds r+1 SHIFT cycles plus 1 rescan cycle.
- A full row 0 is cleared: zeroed with no shift from above.
- top_occupied updates every cycle from row 0, with 1-cycle lag.

Decomposition:
- Shared package tetris_pkg:
  - ROWS/COLS defaults.
  - CW.
  - Colour-code constants (EMPTY=0, I..Z=1..7).
  - FSM state encoding for the clear engine.
- One natural sub-module: row_full_detect (combinational AND-reduce of "cell!=0" across one row, COLS-parametrised), reused by SCAN and by top_occupied (as OR-reduce).
- Storage is one flat register array of ROWS*COLS*CW bits. It is not inferred BRAM, because the shift reads and writes whole rows per cycle.

Test Plan:
1. Reset mid-pass: fill row 19, start a pass, assert reset in SHIFT -> all reads return 0, busy=0, no clr_done, lines_cleared=0.
2. Write (row 3, col 4, val 5), then read the same address -> rd_val=5 one cycle after the read address is applied; write to col 12 is dropped; read at row 25 -> 0.
3. Fill row 19 with val 2, put val 7 at (18,0), pulse clr_start -> clr_done after 20+20+1+1 cycles, lines_cleared=1, (19,0)=7, row 0 all 0.
4. Fill rows 18 and 19 fully, with (17,5)=3 -> lines_cleared=2, (19,5)=3, rows 17-18 empty.
5. During a pass, assert wr_en to (0,0) val 1 and pulse clr_start again -> write dropped, second start ignored, one clr_done only.
6. Write (0,9)=4 -> top_occupied=1 two cycles later; fill row 0 fully and clear -> top_occupied returns to 0, lines_cleared=1.
